// File: rtl/bsg_bp_mem_sched_pkg.sv
// Shared definitions for the BedRock memory link scheduler.
//   state_e : flush/drain FSM states (eRun, eDrain, eDone)
//   lg()    : index width helper, never narrower than one bit
package bsg_bp_mem_sched_pkg;

   typedef enum logic [1:0] {
      eRun   = 2'd0,
      eDrain = 2'd1,
      eDone  = 2'd2
   } state_e;

   // Width needed to index x items (or to hold values 0..x-1), minimum 1.
   function automatic int lg(input int x);
      return (x <= 2) ? 1 : $clog2(x);
   endfunction

endpackage

// File: rtl/bsg_bp_mem_order_fifo.sv
// Order FIFO for the link scheduler: remembers which link each accepted
// command went to, so responses can be returned in command order.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset (pointers only)
//   push_i, data_i   : write a link id (caller guarantees !full_o)
//   pop_i            : drop the head entry (caller guarantees !empty_o)
//   data_o           : head entry
//   full_o, empty_o  : occupancy flags
//   last_o           : exactly one entry held
module bsg_bp_mem_order_fifo
   import bsg_bp_mem_sched_pkg::*;
#(
   parameter int width_p = 1,
   parameter int els_p   = 16
)(
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               push_i,
   input  logic [width_p-1:0] data_i,
   input  logic               pop_i,
   output logic [width_p-1:0] data_o,
   output logic               full_o,
   output logic               empty_o,
   output logic               last_o
);

   localparam int ptr_w = lg(els_p);
   localparam logic [ptr_w:0] ptr_one = (ptr_w+1)'(1);
   localparam logic [ptr_w:0] ptr_els = (ptr_w+1)'(els_p);

   logic [width_p-1:0] mem [els_p];
   // One extra wrap bit on each pointer distinguishes full from empty.
   logic [ptr_w:0] wptr, rptr, count;

   assign count   = wptr - rptr;
   assign full_o  = (count == ptr_els);
   assign empty_o = (count == '0);
   assign last_o  = (count == ptr_one);
   assign data_o  = mem[rptr[ptr_w-1:0]];

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push_i) wptr <= wptr + ptr_one;
         if (pop_i)  rptr <= rptr + ptr_one;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem[wptr[ptr_w-1:0]] <= data_i;
   end

endmodule

// File: rtl/bsg_bp_mem_link_scheduler.sv
// Steers one BedRock memory command stream across num_links_p DRAM links by
// address interleave and returns responses strictly in command order.
// Per-link credits bound outstanding requests; a flush handshake drains all
// in-flight traffic.
// Ports:
//   clk_i, reset_n_i           : clock, asynchronous active-low reset
//   cmd_i/cmd_v_i/cmd_ready_o  : command from the core
//   resp_o/resp_v_o/resp_yumi_i: in-order response to the core
//   link_cmd_o/_v_o/_ready_i   : per-link commands (all lanes carry cmd_i)
//   link_resp_i/_v_i/_yumi_o   : per-link responses
//   flush_i, flush_done_o      : drain request (level) and drain complete
//   issue_count_o              : per-link issued-command counters
// Build option: define BSG_BP_MEM_SCHED_PERF_EN to build the saturating
// issue counters; otherwise issue_count_o is tied to 0.
module bsg_bp_mem_link_scheduler
   import bsg_bp_mem_sched_pkg::*;
#(
   parameter int msg_width_p       = 128,
   parameter int addr_offset_p     = 0,
   parameter int num_links_p       = 2,
   parameter int sel_lsb_p         = 6,
   parameter int max_outstanding_p = 8,
   parameter int order_els_p       = 16
)(
   input  logic                                    clk_i,
   input  logic                                    reset_n_i,
   input  logic [msg_width_p-1:0]                  cmd_i,
   input  logic                                    cmd_v_i,
   output logic                                    cmd_ready_o,
   output logic [msg_width_p-1:0]                  resp_o,
   output logic                                    resp_v_o,
   input  logic                                    resp_yumi_i,
   output logic [num_links_p-1:0][msg_width_p-1:0] link_cmd_o,
   output logic [num_links_p-1:0]                  link_cmd_v_o,
   input  logic [num_links_p-1:0]                  link_cmd_ready_i,
   input  logic [num_links_p-1:0][msg_width_p-1:0] link_resp_i,
   input  logic [num_links_p-1:0]                  link_resp_v_i,
   output logic [num_links_p-1:0]                  link_resp_yumi_o,
   input  logic                                    flush_i,
   output logic                                    flush_done_o,
   output logic [num_links_p-1:0][31:0]            issue_count_o
);

   localparam int sel_w  = lg(num_links_p);
   localparam int cred_w = lg(max_outstanding_p + 1);
   localparam logic [cred_w-1:0] cred_max = cred_w'(max_outstanding_p);
   localparam logic [cred_w-1:0] cred_one = cred_w'(1);

   state_e state, state_next;
   logic [num_links_p-1:0][cred_w-1:0] credit, credit_next;
   logic [sel_w-1:0] sel, head;
   logic order_full, order_empty, order_last;
   logic accept, pop, credits_zero_next;

   // Command path: combinational steer by address interleave.
   assign sel = cmd_i[addr_offset_p + sel_lsb_p +: sel_w];

   // reset_n_i gates the handshakes so they drop as soon as reset asserts.
   assign cmd_ready_o = reset_n_i & link_cmd_ready_i[sel] & (credit[sel] < cred_max)
                        & ~order_full & (state == eRun);
   assign accept      = cmd_v_i & cmd_ready_o;
   assign link_cmd_o  = {num_links_p{cmd_i}};

   always_comb begin
      link_cmd_v_o      = '0;
      link_cmd_v_o[sel] = accept;
   end

   // Response path: only the link at the order head may hand back data; other
   // links hold their responses until they reach the head.
   assign resp_v_o = reset_n_i & ~order_empty & link_resp_v_i[head];
   assign resp_o   = link_resp_i[head];
   assign pop      = resp_yumi_i & resp_v_o;

   always_comb begin
      link_resp_yumi_o       = '0;
      link_resp_yumi_o[head] = pop;
   end

   bsg_bp_mem_order_fifo #(
      .width_p (sel_w),
      .els_p   (order_els_p)
   ) order_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .push_i    (accept),
      .data_i    (sel),
      .pop_i     (pop),
      .data_o    (head),
      .full_o    (order_full),
      .empty_o   (order_empty),
      .last_o    (order_last)
   );

   // Credits: an accept and a return on the same link cancel out.
   always_comb begin
      credit_next = credit;
      for (int i = 0; i < num_links_p; i++) begin
         if ((accept && sel == sel_w'(i)) && !(pop && head == sel_w'(i)))
            credit_next[i] = credit[i] + cred_one;
         else if ((pop && head == sel_w'(i)) && !(accept && sel == sel_w'(i)))
            credit_next[i] = credit[i] - cred_one;
      end
      credits_zero_next = (credit_next == '0);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) credit <= '0;
      else            credit <= credit_next;
   end

   // Flush FSM. Drain completes on the cycle whose updates leave nothing
   // outstanding, so flush_done_o rises the cycle after the final yumi.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) state <= eRun;
      else            state <= state_next;
   end

   always_comb begin
      state_next   = state;
      flush_done_o = 1'b0;
      case (state)
         eRun:   if (flush_i) state_next = eDrain;
         eDrain: if ((order_empty | (order_last & pop)) & credits_zero_next)
                    state_next = eDone;
         eDone: begin
            flush_done_o = 1'b1;
            if (!flush_i) state_next = eRun;
         end
         default: state_next = eRun;
      endcase
   end

`ifdef BSG_BP_MEM_SCHED_PERF_EN
   logic [num_links_p-1:0][31:0] issue_count;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         issue_count <= '0;
      end else begin
         for (int i = 0; i < num_links_p; i++) begin
            if (accept && sel == sel_w'(i) && issue_count[i] != '1)
               issue_count[i] <= issue_count[i] + 32'd1;
         end
      end
   end

   assign issue_count_o = issue_count;
`else
   assign issue_count_o = '0;
`endif

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (reset_n_i) begin
         assert (!(pop && credit[head] == '0));
         for (int i = 0; i < num_links_p; i++)
            assert (!(link_resp_v_i[i] && credit[i] == '0));
      end
   end
`endif

endmodule
